// File: rtl/mul_share_arb_if.sv
// Request/response bundle between the two ALU requesters and the shared multiplier.
// master = requester side, slave = the arbiter.
interface mul_share_arb_if;
   logic [1:0] req_valid;
   logic [1:0] req_ready;
   logic [7:0] req_a;
   logic [7:0] req_b;
   logic       rsp_valid;
   logic       rsp_ready;
   logic       rsp_id;
   logic [7:0] rsp_pro;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_pro
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_pro
   );
endinterface

// File: rtl/mul_share_arb.sv
// Shares one 4x4 multiplier between two requesters; accept -> rsp_valid after WAIT_CYC+1 cycles, one op in flight,
// req_ready held low while busy or while a response waits on rsp_ready. MUL_SHARE_ARB_FIXED_PRIO_EN selects fixed priority.
module mul_share_arb #(
   parameter int unsigned WAIT_CYC = 1
) (
   input  logic            clk,
   input  logic            rst,
   mul_share_arb_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [3:0] CNT_INIT = 4'(WAIT_CYC - 1);

   if (WAIT_CYC < 1 || WAIT_CYC > 15) begin : g_bad_wait_cyc
      $error("mul_share_arb: WAIT_CYC must be within 1..15");
   end

   state_t     state_q, state_d;
   logic [3:0] op_a_q, op_a_d;
   logic [3:0] op_b_q, op_b_d;
   logic [3:0] cnt_q, cnt_d;
   logic       id_q, id_d;
   logic       last_gnt_q, last_gnt_d;
   logic       rsp_valid_q, rsp_valid_d;
   logic       rsp_id_q, rsp_id_d;
   logic [7:0] rsp_pro_q, rsp_pro_d;

   logic       any_req;
   logic       gnt;
   logic [1:0] req_ready;
   logic       accept;

   function automatic logic [7:0] multi4(input logic [3:0] a, input logic [3:0] b);
      return {4'b0000, a} * {4'b0000, b};
   endfunction

   // Winner is only meaningful while some request is valid; last_gnt_q moves on accept only.
   always_comb begin
      any_req = |bus.req_valid;
      if (&bus.req_valid) begin
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
         gnt = 1'b0;
`else
         gnt = ~last_gnt_q;
`endif
      end else begin
         gnt = bus.req_valid[1];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept)          state_d = BUSY;
         BUSY:    if (cnt_q == 4'd0)   state_d = DONE;
         DONE:    if (bus.rsp_ready)   state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   // Output logic: ready only for the winner, and only while idle.
   always_comb begin
      req_ready = 2'b00;
      if (state_q == IDLE && any_req) begin
         req_ready = gnt ? 2'b10 : 2'b01;
      end
      accept = |(bus.req_valid & req_ready);
   end

   // Datapath next values
   always_comb begin
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      cnt_d       = cnt_q;
      id_d        = id_q;
      last_gnt_d  = last_gnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_pro_d   = rsp_pro_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               op_a_d     = gnt ? bus.req_a[7:4] : bus.req_a[3:0];
               op_b_d     = gnt ? bus.req_b[7:4] : bus.req_b[3:0];
               id_d       = gnt;
               last_gnt_d = gnt;
               cnt_d      = CNT_INIT;
            end
         end
         BUSY: begin
            if (cnt_q != 4'd0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               rsp_pro_d   = multi4(op_a_q, op_b_q);
               rsp_id_d    = id_q;
               rsp_valid_d = 1'b1;
            end
         end
         DONE: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_a_q      <= 4'd0;
         op_b_q      <= 4'd0;
         cnt_q       <= 4'd0;
         id_q        <= 1'b0;
         last_gnt_q  <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_pro_q   <= 8'h00;
      end else begin
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         cnt_q       <= cnt_d;
         id_q        <= id_d;
         last_gnt_q  <= last_gnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_pro_q   <= rsp_pro_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_pro   = rsp_pro_q;

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a response scoreboard and per-response latency checks.
module tb_mul_share_arb;
   localparam int WAIT_CYC = 1;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mul_share_arb_if ifc();

   mul_share_arb #(.WAIT_CYC(WAIT_CYC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (ifc)
   );

   int         vec     = 0;
   int         errs    = 0;
   int         cyc     = 0;
   int         acc_cyc = 0;
   logic       prev_vld = 1'b0;
   logic [8:0] exp_q[$];
   logic       rsp_ids[$];
   logic       exp_ids[3];

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vec++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample at the falling edge, then return just after the next rising edge.
   task automatic step();
      logic [8:0] e;
      @(negedge clk);
      chk("rdy_onehot0", {15'd0, $onehot0(ifc.req_ready)}, 16'd1);
      if (!rst) begin
         for (int g = 0; g < 2; g++) begin
            if (ifc.req_valid[g] && ifc.req_ready[g]) begin
               exp_q.push_back({1'(g), 8'(ifc.req_a[4*g +: 4]) * 8'(ifc.req_b[4*g +: 4])});
               acc_cyc = cyc;
            end
         end
      end
      if (ifc.rsp_valid && !prev_vld) chk("latency", 16'(cyc - acc_cyc), 16'(WAIT_CYC + 1));
      prev_vld = ifc.rsp_valid;
      if (ifc.rsp_valid && ifc.rsp_ready) begin
         chk("sb_nonempty", {15'd0, exp_q.size() != 0}, 16'd1);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("rsp_id", 16'(ifc.rsp_id), 16'(e[8]));
            chk("rsp_pro", 16'(ifc.rsp_pro), 16'(e[7:0]));
            rsp_ids.push_back(ifc.rsp_id);
         end
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      for (int i = 0; i < 30 && exp_q.size() != 0; i++) step();
      chk(tag, 16'(exp_q.size()), 16'd0);
   endtask

   initial begin
      rst           = 1'b1;
      ifc.req_valid = 2'b00;
      ifc.req_a     = 8'h00;
      ifc.req_b     = 8'h00;
      ifc.rsp_ready = 1'b0;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_req_ready", 16'(ifc.req_ready), 16'd0);
      chk("rst_rsp_valid", 16'(ifc.rsp_valid), 16'd0);
      chk("rst_rsp_pro",   16'(ifc.rsp_pro),   16'd0);
      chk("rst_rsp_id",    16'(ifc.rsp_id),    16'd0);
      rst = 1'b0;

      // Single request, 3*5
      ifc.req_a = 8'h03; ifc.req_b = 8'h05; ifc.req_valid = 2'b01; ifc.rsp_ready = 1'b1;
      #1;
      chk("t2_req_ready", 16'(ifc.req_ready), 16'h1);
      step();
      ifc.req_valid = 2'b00;
      chk("t2_busy_rdy", 16'(ifc.req_ready), 16'h0);
      chk("t2_busy_vld", 16'(ifc.rsp_valid), 16'h0);
      step();
      chk("t2_rsp_vld", 16'(ifc.rsp_valid), 16'h1);
      step();
      chk("t2_idle_vld", 16'(ifc.rsp_valid), 16'h0);

      // Operand change after accept must not leak into the product
      ifc.req_a = 8'h04; ifc.req_b = 8'h03; ifc.req_valid = 2'b01;
      step();
      ifc.req_valid = 2'b00; ifc.req_a = 8'h09;
      drain("t5_drain");

      // Response backpressure: requester 1, 6*7 held for 5 cycles
      ifc.rsp_ready = 1'b0;
      ifc.req_a = 8'h60; ifc.req_b = 8'h70; ifc.req_valid = 2'b10;
      step();
      ifc.req_valid = 2'b00;
      for (int i = 0; i < 20 && !ifc.rsp_valid; i++) step();
      chk("t4_rsp_vld", 16'(ifc.rsp_valid), 16'h1);
      ifc.req_a = 8'h11; ifc.req_b = 8'h11; ifc.req_valid = 2'b01;
      repeat (5) begin
         chk("t4_hold_pro", 16'(ifc.rsp_pro),   16'h2A);
         chk("t4_hold_id",  16'(ifc.rsp_id),    16'h1);
         chk("t4_hold_rdy", 16'(ifc.req_ready), 16'h0);
         step();
      end
      ifc.req_valid = 2'b00; ifc.rsp_ready = 1'b1;
      step();
      chk("t4_done_vld", 16'(ifc.rsp_valid), 16'h0);

      // Contention, both held continuously
      rsp_ids.delete();
      ifc.req_a = 8'h2F; ifc.req_b = 8'h7F; ifc.req_valid = 2'b11;
      for (int i = 0; i < 60 && rsp_ids.size() < 3; i++) step();
      ifc.req_valid = 2'b00;
`ifdef MUL_SHARE_ARB_FIXED_PRIO_EN
      exp_ids = '{1'b0, 1'b0, 1'b0};
`else
      exp_ids = '{1'b0, 1'b1, 1'b0};
`endif
      chk("t3_rsp_count", 16'(rsp_ids.size()), 16'd3);
      for (int i = 0; i < 3 && i < rsp_ids.size(); i++) chk("t3_order_id", 16'(rsp_ids[i]), 16'(exp_ids[i]));
      drain("t3_drain");

      // Reset while busy discards the transaction
      ifc.req_a = 8'h05; ifc.req_b = 8'h05; ifc.req_valid = 2'b01;
      step();
      ifc.req_valid = 2'b00;
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_q.delete();
      chk("t6_rst_vld", 16'(ifc.rsp_valid), 16'h0);
      chk("t6_rst_rdy", 16'(ifc.req_ready), 16'h0);
      chk("t6_rst_pro", 16'(ifc.rsp_pro),   16'h0);
      repeat (3) begin
         step();
         chk("t6_no_rsp", 16'(ifc.rsp_valid), 16'h0);
      end
      // First contended grant after reset goes to requester 0
      ifc.req_a = 8'h10; ifc.req_b = 8'h1C; ifc.req_valid = 2'b11;
      #1;
      chk("t6_first_gnt", 16'(ifc.req_ready), 16'h1);
      step();
      ifc.req_valid = 2'b00;
      drain("t6_drain");

      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
